pu_compare_initiator: RTL

- Bus-side initiator for the compare PU protocol.
- Accepts one comparison request (two operands, operation code, attribute) over a valid/ready handshake.
- Drives the PU strobes: two wr cycles, a fixed wait, then one oe cycle. Captures the result and returns it over a valid/ready response channel.
- Sits between a test or control agent and one compare PU instance. Shares clk/rst with that PU.

---
 rtl/pu_compare_pkg.sv | 37 +++
 rtl/pu_compare_initiator.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pu_compare_pkg.sv
// Shared definitions for the compare PU and its bus-side initiator:
// operation codes, initiator state encoding and default widths.
package pu_compare_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ATTR_WIDTH  = 4;
  localparam int DEF_SEL_WIDTH   = 3;
  localparam int DEF_WAIT_CYCLES = 1;

  // Wait counter holds up to 15 idle cycles
  localparam int CNT_WIDTH = 4;

  // Operation codes understood by the PU; anything else yields 0
  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_LT  = 3'd1;
  localparam logic [2:0] CMP_LTE = 3'd2;
  localparam logic [2:0] CMP_GT  = 3'd3;
  localparam logic [2:0] CMP_GTE = 3'd4;

  // Initiator state encoding
  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_WR_A_ENC = 3'd1;
  localparam logic [2:0] ST_WR_B_ENC = 3'd2;
  localparam logic [2:0] ST_WAIT_ENC = 3'd3;
  localparam logic [2:0] ST_READ_ENC = 3'd4;
  localparam logic [2:0] ST_RESP_ENC = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE_ENC,
    S_WR_A = ST_WR_A_ENC,
    S_WR_B = ST_WR_B_ENC,
    S_WAIT = ST_WAIT_ENC,
    S_READ = ST_READ_ENC,
    S_RESP = ST_RESP_ENC
  } ini_state_t;

endpackage

// File: rtl/pu_compare_initiator.sv
// Bus-side initiator for the compare PU: takes one request, writes both
// operands to the PU, waits WAIT_CYCLES, reads the result with pu_oe and
// returns it on the response channel.
// Optional: PU_COMPARE_INITIATOR_STATS_EN adds stat_count / stat_busy.
module pu_compare_initiator
  import pu_compare_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ATTR_WIDTH  = DEF_ATTR_WIDTH,
  parameter int SEL_WIDTH   = DEF_SEL_WIDTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [SEL_WIDTH-1:0]  req_op,
  input  logic [ATTR_WIDTH-1:0] req_attr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ATTR_WIDTH-1:0] rsp_attr,
  output logic                  pu_wr,
  output logic                  pu_oe,
  output logic [DATA_WIDTH-1:0] pu_data,
  output logic [ATTR_WIDTH-1:0] pu_attr,
  output logic [SEL_WIDTH-1:0]  pu_op_sel,
  input  logic [DATA_WIDTH-1:0] pu_data_in,
  input  logic [ATTR_WIDTH-1:0] pu_attr_in
`ifdef PU_COMPARE_INITIATOR_STATS_EN
  ,
  output logic [15:0]           stat_count,
  output logic                  stat_busy
`endif
);

  ini_state_t            state, nxt;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [SEL_WIDTH-1:0]  op_q;
  logic [ATTR_WIDTH-1:0] attr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next state and strobes; PU buses are forced to 0 outside write cycles
  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    pu_wr     = 1'b0;
    pu_oe     = 1'b0;
    pu_data   = '0;
    pu_attr   = '0;
    pu_op_sel = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt = S_WR_A;
      end
      S_WR_A: begin
        pu_wr     = 1'b1;
        pu_data   = a_q;
        pu_attr   = attr_q;
        pu_op_sel = op_q;
        nxt       = S_WR_B;
      end
      S_WR_B: begin
        pu_wr     = 1'b1;
        pu_data   = b_q;
        pu_attr   = attr_q;
        pu_op_sel = op_q;
        nxt       = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= CNT_WIDTH'(1)) nxt = S_READ;
      end
      S_READ: begin
        pu_oe = 1'b1;
        nxt   = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Request latch, wait counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      attr_q   <= '0;
      cnt_q    <= '0;
      rsp_data <= '0;
      rsp_attr <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        a_q    <= req_a;
        b_q    <= req_b;
        op_q   <= req_op;
        attr_q <= req_attr;
      end
      if (state == S_WR_B)      cnt_q <= CNT_WIDTH'(WAIT_CYCLES);
      else if (state == S_WAIT) cnt_q <= cnt_q - CNT_WIDTH'(1);
      if (state == S_READ) begin
        rsp_data <= pu_data_in;
        rsp_attr <= pu_attr_in;
      end
    end
  end

`ifdef PU_COMPARE_INITIATOR_STATS_EN
  // Count completed response handshakes; wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stat_count <= '0;
    else if (rsp_valid && rsp_ready)  stat_count <= stat_count + 16'd1;
  end

  assign stat_busy = (state != S_IDLE);
`endif

endmodule
